instruction_sequencer: RTL
==========================

Name: instruction_sequencer

Overview:
Multi-cycle fetch/execute control stage that sits directly upstream of the register file. It holds the program counter and fetches 9-bit instructions from instruction memory through a valid handshake. It decodes each instruction into register-file controls (address, is_immediate, write_enable) plus ALU and accumulator controls, and runs a 2-cycle-per-instruction FSM with branch and halt handling.

Parameters:
pointer_width, 3, register-file address width; also the immediate width.
pc_width, 8, program counter width; the PC wraps modulo 2**pc_width.
instruction_width, 9, instruction word width. Fixed; the bench uses only the default.

Ports:
clock  input  1  sole clock; all state updates on posedge.
reset_n  input  1  reset, asynchronous, active-low.
start  input  1  1-cycle pulse; begins execution from IDLE or HALTED.
instruction  input  instruction_width  instruction memory read data at address pc.
instruction_valid  input  1  instruction is valid this cycle.
acc_zero  input  1  accumulator == 0, sampled in EXECUTE.
pc  output  pc_width  program counter, registered.
rf_address  output  pointer_width  register pointer or immediate value.
rf_is_immediate  output  1  select the immediate value instead of the register.
rf_write_enable  output  1  register-file write strobe; data_in is the accumulator.
alu_op  output  4  opcode forwarded to the ALU.
acc_write_enable  output  1  accumulator load strobe.
busy  output  1  high in FETCH and EXECUTE.
halted  output  1  high in HALTED.
illegal  output  1  reserved opcode trapped; see Optional Feature.

Behaviour:
- Instruction format:
  - [8:5] opcode; [4] immediate flag; [3:0] operand.
  - Non-branch instructions use operand[2:0] as rf_address; operand[3] is ignored.
- Opcodes:
  - 0 NOP; 1 LOAD; 2 STORE; 3 ADD; 4 SUB; 5 AND; 6 OR; 7 XOR; 8 SHL; 9 SHR.
  - A BZ; B BNZ; C JUMP; F HALT; D and E reserved.
- States: IDLE, FETCH, EXECUTE, HALTED.
- Reset (async, reset_n=0): state IDLE, pc=0, instr_q=0, every output 0.
- IDLE: on start go to FETCH with pc=0.
- FETCH:
  - If instruction_valid=1, latch instruction into instr_q and go to EXECUTE.
  - Otherwise stay in FETCH; pc and outputs hold.
- EXECUTE: exactly 1 cycle. Control outputs are combinational decode of instr_q and are asserted only in EXECUTE; all are 0 in other states, including rf_address.
  - LOAD and opcodes 3-9: acc_write_enable=1, alu_op=opcode, rf_address=operand[2:0], rf_is_immediate=bit4.
  - STORE: rf_write_enable=1, rf_is_immediate=0, rf_address=operand[2:0]. The register file writes on the posedge that ends EXECUTE.
  - Branches: target = pc + sign-extended operand[3:0] (range -8..+7), modulo 2**pc_width. Offset 0 is a legal self-loop.
    - BZ taken iff acc_zero=1.
    - BNZ taken iff acc_zero=0.
    - JUMP always taken.
    - No rf/acc strobes on any branch.
  - HALT: go to HALTED; pc holds (it still addresses the HALT instruction).
  - Otherwise pc <= pc+1 (wraps 255 -> 0) and go to FETCH.
- Latency: 2 cycles per instruction with zero fetch wait; each cycle instruction_valid is low in FETCH adds 1 cycle.
- HALTED: start resets pc=0 and goes to FETCH; halted and illegal clear on that edge.
- start while busy=1: ignored.
- reset_n asserted mid-instruction: immediate clear. A STORE in progress does not write.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: opcodes D and E in EXECUTE go to HALTED with illegal=1 and assert no strobes; pc holds.
- Undefined: D and E execute as NOP; illegal is tied 0.

Decomposition:
- Shared package cpu_pkg:
  - opcode_t enum (values above) and seq_state_t enum.
  - Field-position constants OPCODE_MSB/LSB, IMM_BIT, OPERAND_WIDTH.
  - Widths PC_WIDTH and INSTRUCTION_WIDTH.
- Natural sub-module instruction_decode: purely combinational, maps instr_q and state to the strobe and field outputs. The FSM and PC stay in the top module.

Test Plan:
- Reset then start; program LOAD imm 5, STORE r3, HALT with valid always high -> acc_write_enable in cycle 2 with rf_address=5, rf_is_immediate=1; rf_write_enable in cycle 4 with rf_address=3; halted=1 after cycle 6 with pc=2.
- instruction_valid held low 3 cycles in FETCH -> pc and outputs stable, busy=1, EXECUTE delayed by exactly 3 cycles.
- At pc=10, BZ offset -3: acc_zero=1 -> next pc=7; acc_zero=0 -> next pc=11. JUMP offset +7 at pc=252 -> pc=3 (wrap).
- Straight-line NOPs from pc=254 -> pc sequence 254, 255, 0, 1.
- reset_n pulsed low mid-EXECUTE of a STORE -> rf_write_enable drops immediately, pc=0, state IDLE; start during busy is ignored.
- Opcode E: with ILLEGAL_TRAP_EN -> halted=1, illegal=1, pc unchanged; without -> pc+1 and no strobes.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cpu_pkg
// Brief    : Shared opcode/state encodings and instruction field positions.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

  localparam int PC_WIDTH          = 8;
  localparam int INSTRUCTION_WIDTH = 9;
  localparam int POINTER_WIDTH     = 3;

  localparam int OPCODE_MSB    = 8;
  localparam int OPCODE_LSB    = 5;
  localparam int IMM_BIT       = 4;
  localparam int OPERAND_WIDTH = 4;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_LOAD   = 4'h1,
    OP_STORE  = 4'h2,
    OP_ADD    = 4'h3,
    OP_SUB    = 4'h4,
    OP_AND    = 4'h5,
    OP_OR     = 4'h6,
    OP_XOR    = 4'h7,
    OP_SHL    = 4'h8,
    OP_SHR    = 4'h9,
    OP_BZ     = 4'hA,
    OP_BNZ    = 4'hB,
    OP_JUMP   = 4'hC,
    OP_RSVD_D = 4'hD,
    OP_RSVD_E = 4'hE,
    OP_HALT   = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALTED  = 2'd3
  } seq_state_t;

  function automatic opcode_t opcode_of(input logic [INSTRUCTION_WIDTH-1:0] instr);
    return opcode_t'(instr[OPCODE_MSB:OPCODE_LSB]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// Module   : instruction_decode
// Brief    : Combinational decode of the latched instruction into strobes.
// Revision : 1.0
// ============================================================================
module instruction_decode
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 3
) (
  input  seq_state_t                     state,
  input  logic [INSTRUCTION_WIDTH-1:0]   instr,
  output logic [ADDR_WIDTH-1:0]          rf_address,
  output logic                           rf_is_immediate,
  output logic                           rf_write_enable,
  output logic [3:0]                     alu_op,
  output logic                           acc_write_enable,
  output logic                           branch_if_zero,
  output logic                           branch_if_nonzero,
  output logic                           halt,
  output logic                           reserved,
  output logic [OPERAND_WIDTH-1:0]       branch_offset
);

  opcode_t opcode;

  assign opcode        = opcode_of(instr);
  assign branch_offset = instr[OPERAND_WIDTH-1:0];

  // Every strobe and field stays zero outside EXECUTE, including the address.
  always_comb begin
    rf_address        = '0;
    rf_is_immediate   = 1'b0;
    rf_write_enable   = 1'b0;
    alu_op            = 4'h0;
    acc_write_enable  = 1'b0;
    branch_if_zero    = 1'b0;
    branch_if_nonzero = 1'b0;
    halt              = 1'b0;
    reserved          = 1'b0;
    if (state == ST_EXECUTE) begin
      case (opcode)
        OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_SHL, OP_SHR: begin
          acc_write_enable = 1'b1;
          alu_op           = opcode;
          rf_address       = instr[ADDR_WIDTH-1:0];
          rf_is_immediate  = instr[IMM_BIT];
        end
        OP_STORE: begin
          rf_write_enable = 1'b1;
          rf_address      = instr[ADDR_WIDTH-1:0];
        end
        OP_BZ:   branch_if_zero = 1'b1;
        OP_BNZ:  branch_if_nonzero = 1'b1;
        OP_JUMP: begin
          branch_if_zero    = 1'b1;
          branch_if_nonzero = 1'b1;
        end
        OP_HALT:             halt = 1'b1;
        OP_RSVD_D, OP_RSVD_E: reserved = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instruction_sequencer
// Brief    : Two-cycle fetch/execute sequencer with branch and halt handling.
//            Define ILLEGAL_TRAP_EN to trap reserved opcodes D/E into HALTED.
// Revision : 1.0
// ============================================================================
module instruction_sequencer #(
  parameter int POINTER_WIDTH     = 3,
  parameter int PC_WIDTH          = 8,
  parameter int INSTRUCTION_WIDTH = 9
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [INSTRUCTION_WIDTH-1:0]  instruction,
  input  logic                          instruction_valid,
  input  logic                          acc_zero,
  output logic [PC_WIDTH-1:0]           pc,
  output logic [POINTER_WIDTH-1:0]      rf_address,
  output logic                          rf_is_immediate,
  output logic                          rf_write_enable,
  output logic [3:0]                    alu_op,
  output logic                          acc_write_enable,
  output logic                          busy,
  output logic                          halted,
  output logic                          illegal
);

  import cpu_pkg::*;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  seq_state_t                     state;
  seq_state_t                     next_state;
  logic [PC_WIDTH-1:0]            pc_q;
  logic [PC_WIDTH-1:0]            next_pc;
  logic [INSTRUCTION_WIDTH-1:0]   instr_q;
  logic [INSTRUCTION_WIDTH-1:0]   next_instr;

  logic                           branch_if_zero;
  logic                           branch_if_nonzero;
  logic                           halt;
  logic                           reserved;
  logic [OPERAND_WIDTH-1:0]       branch_offset;
  logic                           is_branch;
  logic                           branch_taken;
  logic [PC_WIDTH-1:0]            branch_target;

  instruction_decode #(
    .ADDR_WIDTH (POINTER_WIDTH)
  ) u_decode (
    .state             (state),
    .instr             (instr_q),
    .rf_address        (rf_address),
    .rf_is_immediate   (rf_is_immediate),
    .rf_write_enable   (rf_write_enable),
    .alu_op            (alu_op),
    .acc_write_enable  (acc_write_enable),
    .branch_if_zero    (branch_if_zero),
    .branch_if_nonzero (branch_if_nonzero),
    .halt              (halt),
    .reserved          (reserved),
    .branch_offset     (branch_offset)
  );

  // JUMP raises both conditions, so it is taken whatever acc_zero says.
  assign is_branch     = branch_if_zero | branch_if_nonzero;
  assign branch_taken  = acc_zero ? branch_if_zero : branch_if_nonzero;
  assign branch_target = pc_q + {{(PC_WIDTH-OPERAND_WIDTH){branch_offset[OPERAND_WIDTH-1]}},
                                 branch_offset};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state   <= next_state;
      pc_q    <= next_pc;
      instr_q <= next_instr;
    end
  end

  always_comb begin
    next_state = state;
    next_pc    = pc_q;
    next_instr = instr_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_FETCH;
          next_pc    = '0;
        end
      end
      ST_FETCH: begin
        if (instruction_valid) begin
          next_instr = instruction;
          next_state = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        next_state = ST_FETCH;
        next_pc    = pc_q + PC_WIDTH'(1);
        if (halt || (TRAP_EN && reserved)) begin
          next_state = ST_HALTED;
          next_pc    = pc_q;
        end else if (is_branch && branch_taken) begin
          next_pc = branch_target;
        end
      end
      ST_HALTED: begin
        if (start) begin
          next_state = ST_FETCH;
          next_pc    = '0;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
    end else if (state == ST_EXECUTE && reserved) begin
      illegal_q <= 1'b1;
    end else if (state == ST_HALTED && start) begin
      illegal_q <= 1'b0;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign pc     = pc_q;
  assign busy   = (state == ST_FETCH) || (state == ST_EXECUTE);
  assign halted = (state == ST_HALTED);

endmodule
`default_nettype wire
